// File: rtl/channel_latch_scanner_if.sv
// Bus bundle between the demux stage and the channel latch/scanner.
// master = demux side (drives channel bytes and capture controls), slave = scanner.
interface channel_latch_scanner_if;
    logic [7:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [2:0] sel;
    logic       wr_en;
    logic       clear;
    logic [7:0] scan_data;
    logic [7:0] scan_en;
    logic [2:0] scan_idx;
    logic [7:0] valid;
    logic       frame_done;

    modport master (
        output y0, y1, y2, y3, y4, y5, y6, y7, sel, wr_en, clear,
        input  scan_data, scan_en, scan_idx, valid, frame_done
    );

    modport slave (
        input  y0, y1, y2, y3, y4, y5, y6, y7, sel, wr_en, clear,
        output scan_data, scan_en, scan_idx, valid, frame_done
    );
endinterface

// File: rtl/channel_latch_scanner.sv
// Latches the demux channel byte selected by sel into one of eight holding registers
// and scans the held bytes round-robin onto a one-hot-enabled output bus.
module channel_latch_scanner #(
    parameter int SCAN_DIV   = 4,
    parameter bit SKIP_EMPTY = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    channel_latch_scanner_if.slave  bus
);
    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [7:0] ydata      [8];
    logic [7:0] slot_data  [8];
    logic [7:0] slot_valid;

    assign ydata[0] = bus.y0;
    assign ydata[1] = bus.y1;
    assign ydata[2] = bus.y2;
    assign ydata[3] = bus.y3;
    assign ydata[4] = bus.y4;
    assign ydata[5] = bus.y5;
    assign ydata[6] = bus.y6;
    assign ydata[7] = bus.y7;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            logic [7:0] data_reg;
            logic       valid_reg;

            // clear takes priority over a capture on the same edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg  <= 8'h00;
                    valid_reg <= 1'b0;
                end else if (bus.clear) begin
                    data_reg  <= 8'h00;
                    valid_reg <= 1'b0;
                end else if (bus.wr_en && (bus.sel == 3'(gi))) begin
                    data_reg  <= ydata[gi];
                    valid_reg <= 1'b1;
                end
            end

            assign slot_data[gi]  = data_reg;
            assign slot_valid[gi] = valid_reg;
        end
    endgenerate

    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  idx_reg, idx_next;
    logic        wrap_next;
    logic        tick;
    logic        found;
    logic [2:0]  cand;

    assign tick     = (cnt_reg == DIV_LAST);
    assign cnt_next = tick ? 16'd0 : cnt_reg + 16'd1;

    // Skip mode searches idx+1..idx+8, so a lone valid slot equal to idx is found last and counts as a wrap.
    always_comb begin
        idx_next  = idx_reg;
        wrap_next = 1'b0;
        found     = 1'b0;
        cand      = idx_reg;
        if (tick) begin
            if (!SKIP_EMPTY) begin
                idx_next  = idx_reg + 3'd1;
                wrap_next = (idx_reg == 3'd7);
            end else begin
                for (int k = 1; k <= 8; k++) begin
                    cand = idx_reg + 3'(k);
                    if (!found && slot_valid[cand]) begin
                        found    = 1'b1;
                        idx_next = cand;
                    end
                end
                wrap_next = found && (idx_next <= idx_reg);
            end
        end
    end

    logic [7:0] scan_data_reg;
    logic [7:0] scan_en_reg;
    logic [2:0] scan_idx_reg;
    logic       frame_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= 16'd0;
            idx_reg        <= 3'd0;
            frame_done_reg <= 1'b0;
            scan_data_reg  <= 8'h00;
            scan_en_reg    <= 8'h00;
            scan_idx_reg   <= 3'd0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            frame_done_reg <= wrap_next;
            // Output stage sees the index and slot contents as left by the previous edge.
            scan_idx_reg   <= idx_reg;
            scan_data_reg  <= slot_valid[idx_reg] ? slot_data[idx_reg] : 8'h00;
            scan_en_reg    <= slot_valid[idx_reg] ? (8'd1 << idx_reg) : 8'h00;
        end
    end

    assign bus.scan_data  = scan_data_reg;
    assign bus.scan_en    = scan_en_reg;
    assign bus.scan_idx   = scan_idx_reg;
    assign bus.valid      = slot_valid;
    assign bus.frame_done = frame_done_reg;
endmodule
